uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receives 8N1 asynchronous serial frames on the 100 MHz system clock and delivers each byte as a parallel word with a one-cycle valid strobe. It is the receive stage of the UART path, sitting between the `rx` pin and the PWM/LED control logic. It derives its bit timing internally from `clk_in`, using the same 9600-baud / 100 MHz ratio as the UART clock divider, so no derived clock crosses into it. It flags framing errors and, optionally, parity errors.

## Interface
- `CLKS_PER_BIT`, 10416: `clk_in` cycles per bit (100 MHz / 9600); legal range 4..65535.
- `clk_in`  input  1  system clock, 100 MHz; all logic on its rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  last correctly received byte, LSB received first.
- `rx_valid`  output  1  one-cycle pulse; `rx_data` is new this cycle.
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low.
- `busy`  output  1  high whenever state is not IDLE.
- `parity_err`  output  1  one-cycle pulse (only with `UART_RX_PARITY_EN`).

## Operation
- `rx` passes through a 2-flop synchronizer initialised to 1; only the synchronized value `rx_s` is used.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits.
- States:
  - IDLE: counter = 0. Moves to START when `rx_s` == 0.
  - START: counts to CLKS_PER_BIT/2 − 1 (integer division), then samples `rx_s`.
    - If 0: counter = 0, bit index = 0, go to DATA.
    - If 1: treat as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift register bit [index].
    - After index 7, go to STOP (or PARITY when enabled).
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s` == 1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- `rx_valid`, `frame_err` and `parity_err` are mutually exclusive and each lasts exactly one cycle.
- `rx_data` holds its value until the next valid frame.
- A new start bit is accepted on the cycle after returning to IDLE, so back-to-back frames with a single stop bit are received without loss.
- Reset mid-frame aborts the frame immediately. No strobe is emitted and the partial byte is discarded.

## Timing
- Reset values (next edge with `reset_n` = 0):
  - state = IDLE, all counters = 0, synchronizer = 2'b11, shift register = 0.
  - `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0.
- Falling edge of `rx` to START entry: 3 cycles (2 synchronizer cycles + 1 registered state change).
- START sample point: CLKS_PER_BIT/2 cycles after START entry, i.e. mid start bit.
- Each following sample: exactly CLKS_PER_BIT cycles after the previous one.
- `rx_valid` and `frame_err` are registered: they assert the cycle after the stop-bit sample.
- Total latency, line start edge to `rx_valid`: 3 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles (10 + 1 with parity).
- `busy` rises with START entry and falls on the same edge that asserts `rx_valid`/`frame_err`, or when BREAK exits.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - The 9th bit is sampled and checked for even parity over data + parity bit.
  - On mismatch: `parity_err` pulses at the STOP-sample time, in place of `rx_valid`, and `rx_data` is not updated.
  - A stop-bit error takes precedence: only `frame_err` pulses.
- Not defined: no PARITY state, `parity_err` port absent, 8N1 only.

## Test plan
- Reset (CLKS_PER_BIT = 16): hold `reset_n` low 3 cycles -> all outputs 0, `busy` 0, `rx_data` 8'h00.
- Send 8'h55 in 8N1 at 16 clocks/bit -> single `rx_valid` pulse 3+8+144+1 = 156 cycles after the start edge, `rx_data` = 8'h55, `frame_err` 0.
- 3-cycle low glitch on idle line -> no strobe, `busy` returns to 0 at START's mid-bit sample, next frame 8'hA5 received correctly.
- Frame 8'h3C with stop bit forced low, line then held low 40 cycles -> exactly one `frame_err`, `rx_data` retains prior value; the next frame 8'hC3 gives `rx_valid` with 8'hC3.
- Back-to-back 8'hA5, 8'h3C with no idle gap -> two `rx_valid` pulses exactly 160 cycles apart, correct data each.
- Assert `reset_n` low during data bit 4, release, send 8'h81 -> no strobe for the aborted frame, then `rx_valid` with 8'h81. With `UART_RX_PARITY_EN`, 8'h81 with odd parity bit -> `parity_err` only.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// Parallel output bundle of the UART receive stage.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_deserializer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, busy, parity_err
    );
    modport slave (
        input rx_data, rx_valid, frame_err, busy, parity_err
    );
`else
    modport master (
        output rx_data, rx_valid, frame_err, busy
    );
    modport slave (
        input rx_data, rx_valid, frame_err, busy
    );
`endif
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: 8N1 deserializer with framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   rx,
    uart_rx_deserializer_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [1:0]    sync;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [7:0]    data;
    logic          valid;
    logic          ferr;
    logic          fin;
    logic          stop_q;
`ifdef UART_RX_PARITY_EN
    logic          pbit;
    logic          perr;
`endif

    assign rx_s = sync[1];

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            sync   <= 2'b11;
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            data   <= '0;
            valid  <= 1'b0;
            ferr   <= 1'b0;
            fin    <= 1'b0;
            stop_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit   <= 1'b0;
            perr   <= 1'b0;
`endif
        end else begin
            sync  <= {sync[0], rx};
            valid <= 1'b0;
            ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    fin <= 1'b0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) state <= AFTER_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        pbit  <= rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                // Stop bit is captured first, strobes follow one edge later.
                STOP: begin
                    if (fin) begin
                        fin <= 1'b0;
                        cnt <= '0;
                        if (!stop_q) begin
                            ferr  <= 1'b1;
                            state <= BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shreg, pbit}) begin
                            perr  <= 1'b1;
                            state <= IDLE;
`endif
                        end else begin
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (cnt == FULL) begin
                        fin    <= 1'b1;
                        stop_q <= rx_s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data   = data;
    assign bus.rx_valid  = valid;
    assign bus.frame_err = ferr;
    assign bus.busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer at 16 clocks per bit.
// Frame outcomes are predicted from the line protocol into an event queue.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int LAT   = 3 + CPB / 2 + (NBITS - 1) * CPB + 1;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  q[$];
    int   vcyc[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx_deserializer_if bus();

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in (clk),
        .reset_n(reset_n),
        .rx     (rx),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    logic act_p;
`ifdef UART_RX_PARITY_EN
    assign act_p = bus.parity_err;
`else
    assign act_p = 1'b0;
`endif

    // Per-cycle comparison of strobes and held data against the event model.
    always @(negedge clk) begin
        logic [2:0] want;
        ev_t e;
        if (!reset_n) begin
            exp_data = 8'h00;
        end else begin
            want = 3'b000;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("missed_event", 32'(cyc), 32'(e.cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                want[e.kind] = 1'b1;
                if (e.kind == 0) exp_data = e.data;
            end
            if (bus.rx_valid) vcyc.push_back(cyc);
            chk("strobes", {29'd0, act_p, bus.frame_err, bus.rx_valid},
                {29'd0, want[2], want[1], want[0]});
            chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_data});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit bad_par);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.data = d;
        e.kind = !stop_ok ? 1 : (bad_par ? 2 : 0);
`ifndef UART_RX_PARITY_EN
        if (bad_par) e.kind = 0;
`endif
        q.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ bad_par;
        tick(CPB);
`endif
        rx = stop_ok;
        tick(CPB);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        tick(3);
        reset_n = 1'b1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("reset_data", {24'd0, bus.rx_data}, 32'h00);
        tick(5);

        // single frame, latency pinned by hand
        vcyc.delete();
        s = cyc;
        send_frame(8'h55, 1, 0);
        tick(4);
        chk("h55_data", {24'd0, bus.rx_data}, 32'h55);
        chk("h55_count", 32'(vcyc.size()), 32'd1);
        if (vcyc.size() > 0)
            chk("h55_latency", 32'(vcyc[0] - s), 32'(LAT));
        tick(6);

        // short glitch on idle line
        s = cyc;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        chk("glitch_busy_hi", {31'd0, bus.busy}, 32'd1);
        tick(7);
        chk("glitch_busy_mid", {31'd0, bus.busy}, 32'd1);
        tick(1);
        chk("glitch_busy_lo", {31'd0, bus.busy}, 32'd0);
        tick(10);
        send_frame(8'hA5, 1, 0);
        tick(4);
        chk("hA5_data", {24'd0, bus.rx_data}, 32'hA5);

        // framing error with line held low
        send_frame(8'h3C, 0, 0);
        tick(40);
        chk("break_busy", {31'd0, bus.busy}, 32'd1);
        chk("ferr_keep", {24'd0, bus.rx_data}, 32'hA5);
        rx = 1'b1;
        tick(4);
        chk("break_exit", {31'd0, bus.busy}, 32'd0);
        tick(10);
        send_frame(8'hC3, 1, 0);
        tick(4);
        chk("hC3_data", {24'd0, bus.rx_data}, 32'hC3);
        tick(6);

        // back-to-back frames
        vcyc.delete();
        send_frame(8'hA5, 1, 0);
        send_frame(8'h3C, 1, 0);
        tick(4);
        chk("b2b_count", 32'(vcyc.size()), 32'd2);
        if (vcyc.size() == 2)
            chk("b2b_gap", 32'(vcyc[1] - vcyc[0]), 32'(FRAME));
        chk("b2b_data", {24'd0, bus.rx_data}, 32'h3C);
        tick(6);

        // reset during data bit 4
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(CPB);
        end
        rx = 1'b1;
        tick(8);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_data", {24'd0, bus.rx_data}, 32'h00);
        tick(5);
        send_frame(8'h81, 1, 0);
        tick(4);
        chk("h81_data", {24'd0, bus.rx_data}, 32'h81);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1, 1);
        tick(4);
        chk("par_keep", {24'd0, bus.rx_data}, 32'h81);
`endif

        tick(200);
        chk("pending_events", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
